// File: rtl/oled_spi_sink.sv
// Receive side of the 4-wire OLED SPI link: oversamples the lines, deserializes
// bytes and tracks the SSD1306-style addressing state to emit framebuffer writes.
`timescale 1ns/1ps
module oled_spi_sink #(
  parameter int SYNC_STAGES = 2,
  parameter int NUM_COLS    = 128,
  parameter int NUM_PAGES   = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sck,
  input  logic       mosi,
  input  logic       dc,
  input  logic       cs,
  input  logic       reset_oled,
  output logic       rx_valid,
  output logic [7:0] rx_byte,
  output logic       rx_is_data,
  output logic       fb_we,
  output logic [2:0] fb_page,
  output logic [6:0] fb_col,
  output logic [7:0] fb_data,
  output logic       display_on,
  output logic [1:0] addr_mode,
  output logic       frame_error
);

  localparam logic [6:0] COL_LAST  = 7'(NUM_COLS - 1);
  localparam logic [2:0] PAGE_LAST = 3'(NUM_PAGES - 1);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ARG_MODE = 3'd1,
    ST_ARG_CS   = 3'd2,
    ST_ARG_CE   = 3'd3,
    ST_ARG_PS   = 3'd4,
    ST_ARG_PE   = 3'd5,
    ST_ARG_SKIP = 3'd6
  } state_t;

  function automatic logic [6:0] col_inc(input logic [6:0] c);
    return (c == COL_LAST) ? 7'd0 : c + 7'd1;
  endfunction

  function automatic logic [2:0] page_inc(input logic [2:0] p);
    return (p == PAGE_LAST) ? 3'd0 : p + 3'd1;
  endfunction

  logic [SYNC_STAGES-1:0] sck_sync_r, mosi_sync_r, dc_sync_r, cs_sync_r, run_sync_r;
  logic sck_sync_s, mosi_sync_s, dc_sync_s, cs_sync_s, panel_run_s;
  logic sck_prev_r, sck_rise_s, byte_done_s;
  logic [2:0] bit_cnt_r;
  logic [7:0] shift_r, byte_val_s;

  state_t     state_r, state_n;
  logic [6:0] col_ptr_r, col_ptr_n, col_start_r, col_start_n, col_end_r, col_end_n;
  logic [6:0] arg_hold_r, arg_hold_n;
  logic [2:0] page_ptr_r, page_ptr_n, page_start_r, page_start_n, page_end_r, page_end_n;
  logic [1:0] addr_mode_n;
  logic       display_on_n, fb_we_n;
  logic [2:0] fb_page_n;
  logic [6:0] fb_col_n;
  logic [7:0] fb_data_n;

  // Input synchronizers; cs and reset_oled idle inactive so reset release needs a fresh cs low.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sck_sync_r  <= {SYNC_STAGES{1'b0}};
      mosi_sync_r <= {SYNC_STAGES{1'b0}};
      dc_sync_r   <= {SYNC_STAGES{1'b0}};
      cs_sync_r   <= {SYNC_STAGES{1'b1}};
      run_sync_r  <= {SYNC_STAGES{1'b1}};
    end else begin
      sck_sync_r  <= {sck_sync_r[SYNC_STAGES-2:0], sck};
      mosi_sync_r <= {mosi_sync_r[SYNC_STAGES-2:0], mosi};
      dc_sync_r   <= {dc_sync_r[SYNC_STAGES-2:0], dc};
      cs_sync_r   <= {cs_sync_r[SYNC_STAGES-2:0], cs};
      run_sync_r  <= {run_sync_r[SYNC_STAGES-2:0], reset_oled};
    end
  end

  assign sck_sync_s  = sck_sync_r[SYNC_STAGES-1];
  assign mosi_sync_s = mosi_sync_r[SYNC_STAGES-1];
  assign dc_sync_s   = dc_sync_r[SYNC_STAGES-1];
  assign cs_sync_s   = cs_sync_r[SYNC_STAGES-1];
  assign panel_run_s = run_sync_r[SYNC_STAGES-1];
  assign sck_rise_s  = sck_sync_s & ~sck_prev_r;
  assign byte_val_s  = {shift_r[6:0], mosi_sync_s};
  assign byte_done_s = panel_run_s & ~cs_sync_s & sck_rise_s & (bit_cnt_r == 3'd7);

  // Deserializer: shifts on sck rise, flags a cs rise that cuts a byte short.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sck_prev_r  <= 1'b0;
      bit_cnt_r   <= 3'd0;
      shift_r     <= 8'd0;
      rx_valid    <= 1'b0;
      rx_byte     <= 8'd0;
      rx_is_data  <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      sck_prev_r <= sck_sync_s;
      if (!panel_run_s) begin
        bit_cnt_r   <= 3'd0;
        shift_r     <= 8'd0;
        rx_valid    <= 1'b0;
        rx_byte     <= 8'd0;
        rx_is_data  <= 1'b0;
        frame_error <= 1'b0;
      end else if (cs_sync_s) begin
        bit_cnt_r   <= 3'd0;
        shift_r     <= 8'd0;
        rx_valid    <= 1'b0;
        frame_error <= (bit_cnt_r != 3'd0);
      end else if (sck_rise_s) begin
        bit_cnt_r   <= bit_cnt_r + 3'd1;
        shift_r     <= byte_val_s;
        rx_valid    <= (bit_cnt_r == 3'd7);
        frame_error <= 1'b0;
        if (bit_cnt_r == 3'd7) begin
          rx_byte    <= byte_val_s;
          rx_is_data <= dc_sync_s;
        end else begin
          rx_byte    <= rx_byte;
          rx_is_data <= rx_is_data;
        end
      end else begin
        rx_valid    <= 1'b0;
        frame_error <= 1'b0;
      end
    end
  end

  // Command parser and pointer advance, evaluated on the same edge that raises rx_valid.
  always_comb begin
    state_n      = state_r;
    col_ptr_n    = col_ptr_r;
    col_start_n  = col_start_r;
    col_end_n    = col_end_r;
    arg_hold_n   = arg_hold_r;
    page_ptr_n   = page_ptr_r;
    page_start_n = page_start_r;
    page_end_n   = page_end_r;
    addr_mode_n  = addr_mode;
    display_on_n = display_on;
    fb_we_n      = 1'b0;
    fb_page_n    = fb_page;
    fb_col_n     = fb_col;
    fb_data_n    = fb_data;
    if (!panel_run_s) begin
      state_n      = ST_IDLE;
      col_ptr_n    = 7'd0;
      col_start_n  = 7'd0;
      col_end_n    = COL_LAST;
      arg_hold_n   = 7'd0;
      page_ptr_n   = 3'd0;
      page_start_n = 3'd0;
      page_end_n   = PAGE_LAST;
      addr_mode_n  = 2'b10;
      display_on_n = 1'b0;
      fb_page_n    = 3'd0;
      fb_col_n     = 7'd0;
      fb_data_n    = 8'd0;
    end else if (byte_done_s && dc_sync_s) begin
      // A data byte also aborts any half-received command.
      state_n   = ST_IDLE;
      fb_we_n   = 1'b1;
      fb_page_n = page_ptr_r;
      fb_col_n  = col_ptr_r;
      fb_data_n = byte_val_s;
      case (addr_mode)
        2'b00: begin
          if (col_ptr_r == col_end_r) begin
            col_ptr_n  = col_start_r;
            page_ptr_n = (page_ptr_r == page_end_r) ? page_start_r : page_inc(page_ptr_r);
          end else begin
            col_ptr_n = col_inc(col_ptr_r);
          end
        end
        2'b01: begin
          if (page_ptr_r == page_end_r) begin
            page_ptr_n = page_start_r;
            col_ptr_n  = (col_ptr_r == col_end_r) ? col_start_r : col_inc(col_ptr_r);
          end else begin
            page_ptr_n = page_inc(page_ptr_r);
          end
        end
        default: col_ptr_n = col_inc(col_ptr_r);
      endcase
    end else if (byte_done_s) begin
      state_n = ST_IDLE;
      case (state_r)
        ST_IDLE: begin
          if (byte_val_s[7:4] == 4'h0) begin
            col_ptr_n[3:0] = byte_val_s[3:0];
          end else if (byte_val_s[7:3] == 5'b00010) begin
            col_ptr_n[6:4] = byte_val_s[2:0];
          end else if (byte_val_s[7:3] == 5'b10110) begin
            page_ptr_n = byte_val_s[2:0];
          end else begin
            case (byte_val_s)
              8'h20:        state_n = ST_ARG_MODE;
              8'h21:        state_n = ST_ARG_CS;
              8'h22:        state_n = ST_ARG_PS;
              8'h81, 8'h8D: state_n = ST_ARG_SKIP;
              8'hAE:        display_on_n = 1'b0;
              8'hAF:        display_on_n = 1'b1;
              default:      state_n = ST_IDLE;
            endcase
          end
        end
        ST_ARG_MODE: begin
          if (byte_val_s[1:0] != 2'b11) begin
            addr_mode_n = byte_val_s[1:0];
          end else begin
            addr_mode_n = addr_mode;
          end
        end
        ST_ARG_CS: begin
          // The start is held back so an aborted 0x21 leaves the window intact.
          arg_hold_n = byte_val_s[6:0];
          state_n    = ST_ARG_CE;
        end
        ST_ARG_CE: begin
          col_start_n = arg_hold_r;
          col_end_n   = byte_val_s[6:0];
          col_ptr_n   = arg_hold_r;
        end
        ST_ARG_PS: begin
          arg_hold_n = {4'd0, byte_val_s[2:0]};
          state_n    = ST_ARG_PE;
        end
        ST_ARG_PE: begin
          page_start_n = arg_hold_r[2:0];
          page_end_n   = byte_val_s[2:0];
          page_ptr_n   = arg_hold_r[2:0];
        end
        default: state_n = ST_IDLE;
      endcase
    end else begin
      state_n = state_r;
    end
  end

  // Controller state and framebuffer outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r      <= ST_IDLE;
      col_ptr_r    <= 7'd0;
      col_start_r  <= 7'd0;
      col_end_r    <= COL_LAST;
      arg_hold_r   <= 7'd0;
      page_ptr_r   <= 3'd0;
      page_start_r <= 3'd0;
      page_end_r   <= PAGE_LAST;
      addr_mode    <= 2'b10;
      display_on   <= 1'b0;
      fb_we        <= 1'b0;
      fb_page      <= 3'd0;
      fb_col       <= 7'd0;
      fb_data      <= 8'd0;
    end else begin
      state_r      <= state_n;
      col_ptr_r    <= col_ptr_n;
      col_start_r  <= col_start_n;
      col_end_r    <= col_end_n;
      arg_hold_r   <= arg_hold_n;
      page_ptr_r   <= page_ptr_n;
      page_start_r <= page_start_n;
      page_end_r   <= page_end_n;
      addr_mode    <= addr_mode_n;
      display_on   <= display_on_n;
      fb_we        <= fb_we_n;
      fb_page      <= fb_page_n;
      fb_col       <= fb_col_n;
      fb_data      <= fb_data_n;
    end
  end

endmodule

// File: tb/tb_oled_spi_sink.sv
// Directed bench for oled_spi_sink: a byte table with expected writes plus
// hand-written sequences for framing errors, panel reset and async reset.
`timescale 1ns/1ps
module tb_oled_spi_sink;

  logic clk = 1'b0;
  logic reset, sck, mosi, dc, cs, reset_oled;
  logic rx_valid, rx_is_data, fb_we, display_on, frame_error;
  logic [7:0] rx_byte, fb_data;
  logic [2:0] fb_page;
  logic [6:0] fb_col;
  logic [1:0] addr_mode;

  oled_spi_sink #(.SYNC_STAGES(2), .NUM_COLS(128), .NUM_PAGES(8)) dut (
    .clk(clk), .reset(reset), .sck(sck), .mosi(mosi), .dc(dc), .cs(cs),
    .reset_oled(reset_oled), .rx_valid(rx_valid), .rx_byte(rx_byte),
    .rx_is_data(rx_is_data), .fb_we(fb_we), .fb_page(fb_page), .fb_col(fb_col),
    .fb_data(fb_data), .display_on(display_on), .addr_mode(addr_mode),
    .frame_error(frame_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       dc;
    logic [7:0] b;
    logic       we;
    logic [2:0] page;
    logic [6:0] col;
    logic [1:0] mode;
    logic       disp;
  } vec_t;

  typedef struct {
    logic [7:0] b;
    logic       is_data;
    logic       we;
    logic [2:0] page;
    logic [6:0] col;
    logic [7:0] data;
  } ev_t;

  vec_t vecs[$];
  ev_t  ev_q[$];
  ev_t  mon_e;
  int   fe_cycles = 0;
  int   stray_we = 0;
  int   checks = 0;
  int   errors = 0;

  // Capture every received byte and count frame_error / stray write cycles.
  always @(negedge clk) begin
    if (rx_valid === 1'b1) begin
      mon_e.b       = rx_byte;
      mon_e.is_data = rx_is_data;
      mon_e.we      = fb_we;
      mon_e.page    = fb_page;
      mon_e.col     = fb_col;
      mon_e.data    = fb_data;
      ev_q.push_back(mon_e);
    end
    if (frame_error === 1'b1) fe_cycles++;
    if (fb_we === 1'b1 && rx_valid !== 1'b1) stray_we++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic d, input logic [7:0] b, input logic we, input logic [2:0] p,
                     input logic [6:0] c, input logic [1:0] m, input logic ds);
    vec_t v;
    v.dc = d; v.b = b; v.we = we; v.page = p; v.col = c; v.mode = m; v.disp = ds;
    vecs.push_back(v);
  endtask

  task automatic spi_bit(input logic b, input logic d);
    mosi = b;
    dc   = d;
    repeat (4) @(negedge clk);
    sck = 1'b1;
    repeat (4) @(negedge clk);
    sck = 1'b0;
  endtask

  task automatic send_byte(input logic d, input logic [7:0] b);
    for (int i = 7; i >= 0; i--) spi_bit(b[i], d);
    repeat (4) @(negedge clk);
  endtask

  task automatic get_event(input string name, output ev_t e, output bit ok);
    for (int i = 0; i < 20 && ev_q.size() == 0; i++) @(negedge clk);
    ok = (ev_q.size() != 0);
    check({name, "_rx_valid_seen"}, 32'(ok), 32'd1);
    if (ok) e = ev_q.pop_front();
    else e = '{8'd0, 1'b0, 1'b0, 3'd0, 7'd0, 8'd0};
  endtask

  task automatic run_vectors(input int lo, input int hi);
    ev_t e;
    bit ok;
    for (int i = lo; i <= hi; i++) begin
      string n;
      n = $sformatf("v%0d", i);
      send_byte(vecs[i].dc, vecs[i].b);
      get_event(n, e, ok);
      if (ok) begin
        check({n, "_byte"}, 32'(e.b), 32'(vecs[i].b));
        check({n, "_is_data"}, 32'(e.is_data), 32'(vecs[i].dc));
        check({n, "_fb_we"}, 32'(e.we), 32'(vecs[i].we));
        check({n, "_single"}, 32'(ev_q.size()), 32'd0);
        if (vecs[i].we) begin
          check({n, "_page"}, 32'(e.page), 32'(vecs[i].page));
          check({n, "_col"}, 32'(e.col), 32'(vecs[i].col));
          check({n, "_data"}, 32'(e.data), 32'(vecs[i].b));
        end
      end
      check({n, "_mode"}, 32'(addr_mode), 32'(vecs[i].mode));
      check({n, "_disp"}, 32'(display_on), 32'(vecs[i].disp));
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int a_lo, a_hi, b_lo, b_hi;
    ev_t e;
    bit ok;

    // Phase A: display on, horizontal window, page mode wrap.
    a_lo = 0;
    add(1'b0, 8'hAF, 1'b0, 3'd0, 7'd0,   2'd2, 1'b1);
    add(1'b0, 8'h20, 1'b0, 3'd0, 7'd0,   2'd2, 1'b1);
    add(1'b0, 8'h00, 1'b0, 3'd0, 7'd0,   2'd0, 1'b1);
    add(1'b0, 8'h21, 1'b0, 3'd0, 7'd0,   2'd0, 1'b1);
    add(1'b0, 8'h02, 1'b0, 3'd0, 7'd0,   2'd0, 1'b1);
    add(1'b0, 8'h03, 1'b0, 3'd0, 7'd0,   2'd0, 1'b1);
    add(1'b0, 8'h22, 1'b0, 3'd0, 7'd0,   2'd0, 1'b1);
    add(1'b0, 8'h06, 1'b0, 3'd0, 7'd0,   2'd0, 1'b1);
    add(1'b0, 8'h07, 1'b0, 3'd0, 7'd0,   2'd0, 1'b1);
    add(1'b1, 8'h11, 1'b1, 3'd6, 7'd2,   2'd0, 1'b1);
    add(1'b1, 8'h22, 1'b1, 3'd6, 7'd3,   2'd0, 1'b1);
    add(1'b1, 8'h33, 1'b1, 3'd7, 7'd2,   2'd0, 1'b1);
    add(1'b1, 8'h44, 1'b1, 3'd7, 7'd3,   2'd0, 1'b1);
    add(1'b1, 8'h55, 1'b1, 3'd6, 7'd2,   2'd0, 1'b1);
    add(1'b0, 8'h20, 1'b0, 3'd0, 7'd0,   2'd0, 1'b1);
    add(1'b0, 8'h02, 1'b0, 3'd0, 7'd0,   2'd2, 1'b1);
    add(1'b0, 8'hB3, 1'b0, 3'd0, 7'd0,   2'd2, 1'b1);
    add(1'b0, 8'h0F, 1'b0, 3'd0, 7'd0,   2'd2, 1'b1);
    add(1'b0, 8'h17, 1'b0, 3'd0, 7'd0,   2'd2, 1'b1);
    add(1'b1, 8'hAA, 1'b1, 3'd3, 7'd127, 2'd2, 1'b1);
    add(1'b1, 8'hBB, 1'b1, 3'd3, 7'd0,   2'd2, 1'b1);
    a_hi = vecs.size() - 1;

    // Phase B (after panel reset): aborted 0x21, inverted window, vertical mode.
    b_lo = vecs.size();
    add(1'b0, 8'hAF, 1'b0, 3'd0, 7'd0,   2'd2, 1'b1);
    add(1'b0, 8'h20, 1'b0, 3'd0, 7'd0,   2'd2, 1'b1);
    add(1'b0, 8'h00, 1'b0, 3'd0, 7'd0,   2'd0, 1'b1);
    add(1'b0, 8'h21, 1'b0, 3'd0, 7'd0,   2'd0, 1'b1);
    add(1'b0, 8'h10, 1'b0, 3'd0, 7'd0,   2'd0, 1'b1);
    add(1'b1, 8'h99, 1'b1, 3'd0, 7'd0,   2'd0, 1'b1);
    add(1'b0, 8'h0F, 1'b0, 3'd0, 7'd0,   2'd0, 1'b1);
    add(1'b0, 8'h17, 1'b0, 3'd0, 7'd0,   2'd0, 1'b1);
    add(1'b1, 8'h01, 1'b1, 3'd0, 7'd127, 2'd0, 1'b1);
    add(1'b1, 8'h02, 1'b1, 3'd1, 7'd0,   2'd0, 1'b1);
    add(1'b0, 8'h21, 1'b0, 3'd0, 7'd0,   2'd0, 1'b1);
    add(1'b0, 8'h7E, 1'b0, 3'd0, 7'd0,   2'd0, 1'b1);
    add(1'b0, 8'h01, 1'b0, 3'd0, 7'd0,   2'd0, 1'b1);
    add(1'b1, 8'h03, 1'b1, 3'd1, 7'd126, 2'd0, 1'b1);
    add(1'b1, 8'h04, 1'b1, 3'd1, 7'd127, 2'd0, 1'b1);
    add(1'b1, 8'h05, 1'b1, 3'd1, 7'd0,   2'd0, 1'b1);
    add(1'b1, 8'h06, 1'b1, 3'd1, 7'd1,   2'd0, 1'b1);
    add(1'b1, 8'h07, 1'b1, 3'd2, 7'd126, 2'd0, 1'b1);
    add(1'b0, 8'h20, 1'b0, 3'd0, 7'd0,   2'd0, 1'b1);
    add(1'b0, 8'h01, 1'b0, 3'd0, 7'd0,   2'd1, 1'b1);
    add(1'b1, 8'h08, 1'b1, 3'd2, 7'd127, 2'd1, 1'b1);
    add(1'b0, 8'h22, 1'b0, 3'd0, 7'd0,   2'd1, 1'b1);
    add(1'b0, 8'h07, 1'b0, 3'd0, 7'd0,   2'd1, 1'b1);
    add(1'b0, 8'h07, 1'b0, 3'd0, 7'd0,   2'd1, 1'b1);
    add(1'b1, 8'h09, 1'b1, 3'd7, 7'd127, 2'd1, 1'b1);
    add(1'b1, 8'h0A, 1'b1, 3'd7, 7'd0,   2'd1, 1'b1);
    b_hi = vecs.size() - 1;

    reset = 1'b1; sck = 1'b0; mosi = 1'b0; dc = 1'b0; cs = 1'b1; reset_oled = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_rx_valid", 32'(rx_valid), 32'd0);
    check("rst_rx_byte", 32'(rx_byte), 32'd0);
    check("rst_fb_we", 32'(fb_we), 32'd0);
    check("rst_fb_page", 32'(fb_page), 32'd0);
    check("rst_fb_col", 32'(fb_col), 32'd0);
    check("rst_fb_data", 32'(fb_data), 32'd0);
    check("rst_display_on", 32'(display_on), 32'd0);
    check("rst_addr_mode", 32'(addr_mode), 32'd2);
    check("rst_frame_error", 32'(frame_error), 32'd0);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    cs = 1'b0;
    repeat (4) @(negedge clk);

    run_vectors(a_lo, a_hi);

    // Five bits then cs high: one-cycle frame_error, byte dropped.
    for (int i = 0; i < 5; i++) spi_bit(1'b1, 1'b0);
    cs = 1'b1;
    repeat (10) @(negedge clk);
    check("frame_error_cycles", 32'(fe_cycles), 32'd1);
    check("frame_no_rx_valid", 32'(ev_q.size()), 32'd0);
    cs = 1'b0;
    repeat (4) @(negedge clk);
    send_byte(1'b0, 8'h5A);
    get_event("after_frame", e, ok);
    if (ok) begin
      check("after_frame_byte", 32'(e.b), 32'h5A);
      check("after_frame_is_data", 32'(e.is_data), 32'd0);
      check("after_frame_fb_we", 32'(e.we), 32'd0);
    end

    // Panel reset mid-byte: state back to reset values, no frame_error.
    for (int i = 0; i < 3; i++) spi_bit(1'b1, 1'b1);
    reset_oled = 1'b0;
    repeat (8) @(negedge clk);
    check("poled_display_on", 32'(display_on), 32'd0);
    check("poled_addr_mode", 32'(addr_mode), 32'd2);
    check("poled_fb_page", 32'(fb_page), 32'd0);
    check("poled_fb_col", 32'(fb_col), 32'd0);
    check("poled_fb_data", 32'(fb_data), 32'd0);
    check("poled_rx_byte", 32'(rx_byte), 32'd0);
    reset_oled = 1'b1;
    repeat (4) @(negedge clk);
    cs = 1'b1;
    repeat (8) @(negedge clk);
    cs = 1'b0;
    repeat (4) @(negedge clk);
    check("poled_no_frame_error", 32'(fe_cycles), 32'd1);
    check("poled_no_rx_valid", 32'(ev_q.size()), 32'd0);

    run_vectors(b_lo, b_hi);
    check("stray_fb_we", 32'(stray_we), 32'd0);

    // Async reset mid-transfer clears outputs before the next clock edge.
    for (int i = 0; i < 3; i++) spi_bit(1'b1, 1'b1);
    @(posedge clk);
    #3 reset = 1'b1;
    #1;
    check("async_display_on", 32'(display_on), 32'd0);
    check("async_addr_mode", 32'(addr_mode), 32'd2);
    check("async_fb_page", 32'(fb_page), 32'd0);
    check("async_fb_col", 32'(fb_col), 32'd0);
    check("async_fb_data", 32'(fb_data), 32'd0);
    check("async_rx_byte", 32'(rx_byte), 32'd0);
    check("async_rx_is_data", 32'(rx_is_data), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
